// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Byte-stream boot loader that drives the CPU boot-write port. Bytes arrive
// from the UART receiver and are framed as:
//
//   MAGIC, LEN_LO, LEN_HI, LEN x {b0, b1, b2, b3} (little-endian words), CHK
//
// CHK is the XOR of LEN_LO, LEN_HI and every data byte. Each assembled word
// is written to IM/DM with a one-cycle boot_we strobe at byte address
// 4*word_index. boot_en stays high, which keeps the PC frozen, until a whole
// frame has arrived with a good checksum. After that the loader ignores all
// further bytes until reset.
//
// Ports
//   clk         in   1       system clock, all logic on posedge
//   rst_n       in   1       asynchronous, active-low reset
//   rx_data     in   8       received byte, qualified by rx_valid
//   rx_valid    in   1       one-cycle byte strobe, may be back-to-back
//   boot_en     out  1       1 = CPU held in boot, 0 = CPU runs
//   boot_we     out  1       one-cycle write strobe to IM/DM
//   boot_waddr  out  ADDR_W  byte address of the word being written
//   boot_wdata  out  32      word being written
//   done        out  1       image loaded and checksum good (sticky)
//   err         out  1       frame error seen, cleared by the next MAGIC
//   err_code    out  2       01 timeout, 10 length too big, 11 bad checksum
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter int          ADDR_W      = 15,
  parameter int          MAX_WORDS   = 8192,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              boot_en,
  output logic              boot_we,
  output logic [ADDR_W-1:0] boot_waddr,
  output logic [31:0]       boot_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]      MAX_LEN = 16'(MAX_WORDS);

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_LENGTH  = 2'b10;
  localparam logic [1:0] CODE_CHKSUM  = 2'b11;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_reg, state_next;

  // Datapath registers
  logic [7:0]        len_lo_reg;
  logic [15:0]       words_left_reg;
  logic [1:0]        bi_reg;
  logic [23:0]       asm_reg;
  logic [7:0]        chk_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic              done_reg;
  logic              err_reg;
  logic [1:0]        err_code_reg;

  // Decode signals from the next-state logic
  logic              frame_start;
  logic              err_set;
  logic [1:0]        err_code_set;
  logic              timer_active;
  logic              timeout_hit;
  logic [15:0]       len_in;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_SYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    frame_start  = 1'b0;
    err_set      = 1'b0;
    err_code_set = 2'b00;
    len_in       = {rx_data, len_lo_reg};

    // Idle time only counts while a frame is in progress.
    timer_active = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                   (state_reg == S_DATA)   || (state_reg == S_CHK);
    timeout_hit  = timer_active && !rx_valid && (to_cnt_reg == TO_LAST);

    case (state_reg)
      S_SYNC: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          state_next  = S_LEN_LO;
          frame_start = 1'b1;
        end
      end

      S_LEN_LO: begin
        if (rx_valid) begin
          state_next = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (rx_valid) begin
          if (len_in > MAX_LEN) begin
            state_next   = S_ERR;
            err_set      = 1'b1;
            err_code_set = CODE_LENGTH;
          end else if (len_in == 16'd0) begin
            state_next = S_CHK;
          end else begin
            state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        // The last byte of the last word moves on to the checksum byte; the
        // write strobe for that word fires on the following cycle, so the
        // earliest possible DONE is still one cycle after the final write.
        if (rx_valid && (bi_reg == 2'd3) && (words_left_reg == 16'd1)) begin
          state_next = S_CHK;
        end
      end

      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_reg) begin
            state_next = S_DONE;
          end else begin
            state_next   = S_ERR;
            err_set      = 1'b1;
            err_code_set = CODE_CHKSUM;
          end
        end
      end

      S_DONE: begin
        state_next = S_DONE;
      end

      S_ERR: begin
        state_next = S_SYNC;
      end

      default: begin
        state_next = S_SYNC;
      end
    endcase

    // A timeout only fires on a cycle without a byte, so it never competes
    // with the byte-driven transitions above.
    if (timeout_hit) begin
      state_next   = S_ERR;
      err_set      = 1'b1;
      err_code_set = CODE_TIMEOUT;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: length, checksum, word assembly and write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_reg     <= 8'h00;
      words_left_reg <= 16'h0000;
      bi_reg         <= 2'd0;
      asm_reg        <= 24'h000000;
      chk_reg        <= 8'h00;
      we_reg         <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= 32'h0000_0000;
    end else begin
      we_reg <= 1'b0;

      // Address advances on the cycle after each strobe. After the last word
      // of a full-size image this wraps to zero with no write behind it.
      if (we_reg) begin
        waddr_reg <= waddr_reg + ADDR_W'(4);
      end

      case (state_reg)
        S_SYNC: begin
          if (frame_start) begin
            chk_reg   <= 8'h00;
            waddr_reg <= '0;
            bi_reg    <= 2'd0;
          end
        end

        S_LEN_LO: begin
          if (rx_valid) begin
            len_lo_reg <= rx_data;
            chk_reg    <= chk_reg ^ rx_data;
          end
        end

        S_LEN_HI: begin
          if (rx_valid) begin
            words_left_reg <= len_in;
            chk_reg        <= chk_reg ^ rx_data;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            chk_reg <= chk_reg ^ rx_data;
            // The assembly register is separate from boot_wdata, so the next
            // word can start filling while the previous one is being written.
            case (bi_reg)
              2'd0: asm_reg[7:0]   <= rx_data;
              2'd1: asm_reg[15:8]  <= rx_data;
              2'd2: asm_reg[23:16] <= rx_data;
              default: begin
                wdata_reg      <= {rx_data, asm_reg};
                we_reg         <= 1'b1;
                words_left_reg <= words_left_reg - 16'd1;
              end
            endcase
            bi_reg <= bi_reg + 2'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (!timer_active || rx_valid) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      if (state_next == S_DONE) begin
        done_reg <= 1'b1;
      end
      if (frame_start) begin
        err_reg      <= 1'b0;
        err_code_reg <= 2'b00;
      end
      if (err_set) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_code_set;
      end
    end
  end

  // The CPU is released only by a completed, checksum-good image; done is
  // sticky, so the release is too.
  assign boot_en    = ~done_reg;
  assign boot_we    = we_reg;
  assign boot_waddr = waddr_reg;
  assign boot_wdata = wdata_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Directed test of boot_loader. Stimulus pushes the expected boot-write
// transactions into a queue; a monitor pops and compares one entry per
// boot_we pulse. Status outputs are checked directly after key bytes.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  localparam int         ADDR_W  = 15;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] MAGIC   = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              boot_en;
  logic              boot_we;
  logic [ADDR_W-1:0] boot_waddr;
  logic [31:0]       boot_wdata;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  always #5 clk = ~clk;

  boot_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (8192),
    .MAGIC       (MAGIC),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .boot_en    (boot_en),
    .boot_we    (boot_we),
    .boot_waddr (boot_waddr),
    .boot_wdata (boot_wdata),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: one scoreboard entry per boot_we pulse.
  always @(negedge clk) begin : write_monitor
    wr_t e;
    if (rst_n && boot_we) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected", boot_waddr, boot_wdata);
      end else begin
        e = exp_q.pop_front();
        $display("write addr=0x%04h data=0x%08h (expected 0x%04h 0x%08h)", boot_waddr, boot_wdata, e.addr, e.data);
        check("write_addr", 32'(boot_waddr), 32'(e.addr));
        check("write_data", boot_wdata, e.data);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_boot_en"},    32'(boot_en),    32'd1);
    check({tag, "_boot_we"},    32'(boot_we),    32'd0);
    check({tag, "_boot_waddr"}, 32'(boot_waddr), 32'd0);
    check({tag, "_boot_wdata"}, boot_wdata,      32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_err_code"},   32'(err_code),   32'd0);
  endtask

  // Sends MAGIC, LEN, the words little-endian and the checksum XORed with
  // chk_mask (zero mask = correct checksum). Expected writes are queued first.
  task automatic run_frame(input logic [31:0] words[$], input logic [7:0] chk_mask, input int gap);
    logic [7:0]  chk;
    logic [15:0] len;
    logic [31:0] w;
    wr_t         e;
    len = 16'(words.size());
    chk = len[7:0] ^ len[15:8];
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      chk = chk ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      e.addr = ADDR_W'(4 * i);
      e.data = w;
      exp_q.push_back(e);
    end
    $display("frame len=%0d chk=0x%02h gap=%0d", len, chk ^ chk_mask, gap);
    send_byte(MAGIC, gap);
    check("err_clear_on_magic", 32'(err), 32'd0);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gap);
      end
    end
    check("boot_en_before_chk", 32'(boot_en), 32'd1);
    send_byte(chk ^ chk_mask, gap);
  endtask

  logic [31:0] img[$];
  int          n;

  initial begin
    img = '{32'h1234_5678, 32'hDEAD_BEEF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Length too large: 0x2101 words
    $display("test: length overflow");
    send_byte(MAGIC, 1);
    send_byte(8'h01, 1);
    send_byte(8'h21, 0);
    check("len_err", 32'(err), 32'd1);
    check("len_err_code", 32'(err_code), 32'd2);
    check("len_boot_en", 32'(boot_en), 32'd1);
    check("len_done", 32'(done), 32'd0);
    repeat (2) begin @(posedge clk); #1; end

    // Boundary: exactly MAX_WORDS is accepted
    $display("test: length at limit");
    send_byte(MAGIC, 0);
    check("limit_err_cleared", 32'(err), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    check("limit_no_err", 32'(err), 32'd0);
    do_reset();

    // Timeout after one data byte
    $display("test: timeout");
    send_byte(MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    check("to_err_early", 32'(err), 32'd0);
    n = 0;
    while (!err && n < 3 * TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_err", 32'(err), 32'd1);
    check("to_err_code", 32'(err_code), 32'd1);
    check("to_idle_cycles", 32'(n), 32'(TIMEOUT));
    repeat (2) begin @(posedge clk); #1; end

    // Good two-word image, spaced bytes (recovering from the timeout error)
    $display("test: good frame");
    run_frame(img, 8'h00, 2);
    check("good_done", 32'(done), 32'd1);
    check("good_boot_en", 32'(boot_en), 32'd0);
    check("good_err", 32'(err), 32'd0);
    check("good_err_code", 32'(err_code), 32'd0);
    check("good_waddr_final", 32'(boot_waddr), 32'd8);
    // Bytes after DONE are ignored
    send_byte(MAGIC, 1);
    check("done_sticky", 32'(done), 32'd1);
    do_reset();

    // Bad checksum (mask 0x28 makes the sent CHK 0x00), then a good frame
    $display("test: bad checksum then good frame");
    run_frame(img, 8'h28, 1);
    check("bad_err", 32'(err), 32'd1);
    check("bad_err_code", 32'(err_code), 32'd3);
    check("bad_boot_en", 32'(boot_en), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    run_frame(img, 8'h00, 0);
    check("recover_done", 32'(done), 32'd1);
    check("recover_err", 32'(err), 32'd0);
    check("recover_boot_en", 32'(boot_en), 32'd0);
    do_reset();

    // Zero-length frame with leading junk, back-to-back bytes
    $display("test: zero-length frame");
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(MAGIC, 0);
    check("zero_done_a5", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    check("zero_done_1", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    check("zero_done_2", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    check("zero_done_3", 32'(done), 32'd1);
    check("zero_boot_en", 32'(boot_en), 32'd0);
    check("zero_err", 32'(err), 32'd0);
    do_reset();

    // Reset mid-frame after the 2nd data byte, then full replay
    $display("test: reset mid-frame");
    send_byte(MAGIC, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    rst_n = 1'b0;
    #2;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(img, 8'h00, 1);
    check("replay_done", 32'(done), 32'd1);
    check("replay_boot_en", 32'(boot_en), 32'd0);
    check("replay_err", 32'(err), 32'd0);

    repeat (4) begin @(posedge clk); #1; end
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
